dmem_ctrl: RTL

- Multi-cycle data-memory controller for the MEM stage of the MIPS pipeline.
- Extends the single-cycle byte-addressable data memory in three ways:
  - parametrised access latency, with a stall handshake to the hazard unit;
  - alignment and illegal-request detection, with a faulting-address capture register;
  - a read-only word port for the debug unit.
- Supports byte, halfword and word loads and stores; loads are sign- or zero-extended.

---
 rtl/dmem_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle, byte-addressable data memory for the MEM stage.
// Accepts byte, halfword and word loads and stores. A load is sign- or
// zero-extended into the registered o_read_data. An accepted access holds
// o_stall high for LATENCY cycles, and o_done pulses in the cycle after that.
// A misaligned, reserved-size or read+write request is rejected. Rejection
// pulses o_fault and latches the request address into o_fault_addr.
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_mem_addr, i_mem_data       request address / right-justified store data
//   i_mem_read_CU, i_mem_write_CU, i_BHW_CU  request type, {unsigned, size}
//   i_dbg_addr / o_dbg_data      independent debug word read, 1-cycle latency
//   o_read_data, o_stall, o_done, o_fault, o_fault_addr
module dmem_ctrl #(
  parameter int NB_WIDTH = 32,
  parameter int NB_ADDR  = 9,
  parameter int NB_DATA  = 8,
  parameter int LATENCY  = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NB_WIDTH-1:0] i_mem_addr,
  input  logic [NB_WIDTH-1:0] i_mem_data,
  input  logic                i_mem_read_CU,
  input  logic                i_mem_write_CU,
  input  logic [2:0]          i_BHW_CU,
  input  logic [NB_ADDR-3:0]  i_dbg_addr,
  output logic [NB_WIDTH-1:0] o_read_data,
  output logic                o_stall,
  output logic                o_done,
  output logic                o_fault,
  output logic [NB_WIDTH-1:0] o_fault_addr,
  output logic [NB_WIDTH-1:0] o_dbg_data
);
  localparam int NLANES = NB_WIDTH / NB_DATA;
  localparam int DEPTH  = 1 << NB_ADDR;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic [NB_DATA-1:0]  mem [DEPTH];

  logic [NB_ADDR-1:0]  r_addr;
  logic [NB_WIDTH-1:0] r_data;
  logic [1:0]          r_size;
  logic                r_uns;
  logic                r_wr;

  logic                bad, valid, fault, commit;
  logic [NB_ADDR-1:0]  a_addr, wbase, dbase;
  logic [NB_WIDTH-1:0] a_data, rword, shifted, ld, wdata, dword;
  logic [1:0]          a_size;
  logic                a_uns, a_wr;
  logic [NLANES-1:0]   base_mask, be;

  always_comb begin
    bad = (i_mem_read_CU & i_mem_write_CU)
        | (i_BHW_CU[1:0] == 2'b10)
        | ((i_BHW_CU[1:0] == 2'b01) & i_mem_addr[0])
        | ((i_BHW_CU[1:0] == 2'b11) & (i_mem_addr[1:0] != 2'b00));
    valid  = i_reset & (state == IDLE) & (i_mem_read_CU ^ i_mem_write_CU) & ~bad;
    fault  = i_reset & (state == IDLE) & (i_mem_read_CU | i_mem_write_CU) & bad;
    commit = i_reset & (((state == BUSY) & (cnt == 4'd1)) | ((LATENCY == 1) & valid));
    o_stall = valid | (state == BUSY);
    o_fault = fault;

    // With LATENCY=1 the access completes on the acceptance edge, so the
    // live request inputs feed the datapath instead of the captured copy.
    if (state == IDLE) begin
      a_addr = i_mem_addr[NB_ADDR-1:0];
      a_data = i_mem_data;
      a_size = i_BHW_CU[1:0];
      a_uns  = i_BHW_CU[2];
      a_wr   = i_mem_write_CU;
    end else begin
      a_addr = r_addr;
      a_data = r_data;
      a_size = r_size;
      a_uns  = r_uns;
      a_wr   = r_wr;
    end

    wbase = {a_addr[NB_ADDR-1:2], 2'b00};
    dbase = {i_dbg_addr, 2'b00};
    rword = '0;
    dword = '0;
    for (int unsigned k = 0; k < NLANES; k++) begin
      rword[k*NB_DATA +: NB_DATA] = mem[wbase | NB_ADDR'(k)];
      dword[k*NB_DATA +: NB_DATA] = mem[dbase | NB_ADDR'(k)];
    end

    // Load: bring the addressed lane(s) down to bit 0, then extend.
    shifted = rword >> {a_addr[1:0], 3'b000};
    case (a_size)
      2'b00:   ld = {{(NB_WIDTH-NB_DATA){~a_uns & shifted[NB_DATA-1]}},
                     shifted[NB_DATA-1:0]};
      2'b01:   ld = {{(NB_WIDTH-2*NB_DATA){~a_uns & shifted[2*NB_DATA-1]}},
                     shifted[2*NB_DATA-1:0]};
      default: ld = shifted;
    endcase

    // Store: move right-justified data and its lane mask up to the lanes.
    base_mask = '0;
    case (a_size)
      2'b00:   base_mask[0]   = 1'b1;
      2'b01:   base_mask[1:0] = '1;
      default: base_mask      = '1;
    endcase
    be    = base_mask << a_addr[1:0];
    wdata = a_data << {a_addr[1:0], 3'b000};
  end

  // The storage array is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (commit && a_wr) begin
      for (int unsigned k = 0; k < NLANES; k++) begin
        if (be[k]) mem[wbase | NB_ADDR'(k)] <= wdata[k*NB_DATA +: NB_DATA];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state        <= IDLE;
      cnt          <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_size       <= '0;
      r_uns        <= 1'b0;
      r_wr         <= 1'b0;
      o_read_data  <= '0;
      o_done       <= 1'b0;
      o_fault_addr <= '0;
      o_dbg_data   <= '0;
    end else begin
      o_done     <= commit;
      o_dbg_data <= dword;
      if (commit && !a_wr) o_read_data <= ld;
      case (state)
        IDLE: begin
          if (fault) o_fault_addr <= i_mem_addr;
          if (valid) begin
            r_addr <= i_mem_addr[NB_ADDR-1:0];
            r_data <= i_mem_data;
            r_size <= i_BHW_CU[1:0];
            r_uns  <= i_BHW_CU[2];
            r_wr   <= i_mem_write_CU;
            if (LATENCY == 1) begin
              state <= DONE;
            end else begin
              state <= BUSY;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
